imem_responder: RTL and testbench
=================================

IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- DEPTH, 1024, instruction words stored.
- IDX_W, 10, index width; DEPTH = 2**IDX_W.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, input, 1, sole clock; all state updates on posedge.
- reset_n, input, 1, asynchronous active-low reset.
- address, input, 30, word address from fetch unit (byte address without 2 LSBs).
- req, input, 1, fetch request.
- ready, output, 1, responder accepts a fetch this cycle.
- instr, output, 32, fetched instruction word.
- instr_valid, output, 1, instr holds the response to the last accepted fetch.
- fault, output, 1, last accepted fetch was out of range.
- load_en, input, 1, program-load write strobe.
- load_addr, input, IDX_W, program-load word index.
- load_data, input, 32, program-load word.
- run, input, 1, one-cycle pulse ending the load phase.
- fetch_count, output, 32, accepted-fetch counter.

Function
REQ-003 The block SHALL implement FSM states LOAD and RUN; reset state SHALL be LOAD.
REQ-004 In LOAD: ready SHALL be 0, req ignored, each cycle with load_en=1 SHALL write load_data to mem[load_addr].
REQ-005 LOAD->RUN SHALL occur on run=1 with load_en=0; run with load_en=1 SHALL perform the write and remain in LOAD.
REQ-006 In RUN: ready SHALL be 1 unless load_en=1; a fetch is accepted when req=1 and ready=1.
REQ-007 Accepted fetch at cycle N SHALL drive instr and instr_valid=1 at cycle N+1 (one-cycle latency); throughput SHALL be one fetch per cycle back-to-back.
REQ-008 In-range fetch (address[29:IDX_W]==0) SHALL return mem[address[IDX_W-1:0]] with fault=0.
REQ-009 Out-of-range fetch SHALL return instr=32'h00000000 with fault=1 and instr_valid=1; memory SHALL NOT be read.
REQ-010 With no accepted fetch at cycle N, instr_valid SHALL be 0 at N+1; instr and fault SHALL hold their last values.
REQ-011 load_en=1 in RUN SHALL take priority over req: the write completes, no fetch is accepted that cycle, and the state returns to LOAD.
REQ-012 Same-cycle write and read of one index cannot occur (REQ-011); a read in the cycle after a write SHALL return the new data.
REQ-013 fetch_count SHALL increment by 1 per accepted fetch, faults included, and wrap from 32'hFFFFFFFF to 0.
REQ-014 Index arithmetic SHALL truncate address to IDX_W bits only after the range check; no sign extension.

Reset
REQ-015 reset_n=0 SHALL asynchronously force: state=LOAD, ready=0, instr=0, instr_valid=0, fault=0, fetch_count=0.
REQ-016 Memory contents SHALL NOT be cleared by reset.
REQ-017 Reset asserted mid-fetch SHALL discard the pending response; the first post-reset instr_valid=1 requires a new load/run sequence and an accepted fetch.
REQ-018 Release of reset_n SHALL take effect at the next posedge clk; no fetch is accepted in the release cycle.

Structure
REQ-019 The state encoding (LOAD=1'b0, RUN=1'b1), DEPTH/IDX_W defaults and the NOP constant 32'h00000000 SHALL reside in the shared package/define file used by the datapath.
REQ-020 Storage SHALL be one sub-module, imem_array: a synchronous single-port RAM (one write or one read per cycle), no reset; FSM, range check and counter SHALL stay in imem_responder.

Verification
REQ-021 The bench SHALL cover:
- Load: mem[0]=32'h20080005, mem[1]=32'h21290001, pulse run, fetch address 0 then 1 back-to-back -> instr 32'h20080005 at N+1 and 32'h21290001 at N+2, instr_valid=1 both cycles, fetch_count=2.
- Out of range: fetch address 30'h400 -> instr=0, fault=1, instr_valid=1; next in-range fetch -> fault=0.
- Idle: req=0 in RUN -> instr_valid=0 next cycle, instr unchanged.
- Priority: req=1 and load_en=1 in RUN -> no response, state LOAD, ready=0; the written word is readable after the next run.
- Reset: reset_n low mid-stream -> all outputs 0 immediately; memory retained; after run, fetch address 0 returns 32'h20080005.
- Counter wrap: force fetch_count to 32'hFFFFFFFF, one fetch -> fetch_count 0.

Source files
------------

// File: rtl/imem_responder_pkg.sv
// Shared constants and types for the instruction-memory responder.
//   IMEM_DEPTH / IMEM_IDX_W : default storage geometry (DEPTH = 2**IDX_W)
//   NOP_INSTR               : word returned for an out-of-range fetch
//   state_e                 : responder FSM states (LOAD = 1'b0, RUN = 1'b1)
package imem_responder_pkg;

   localparam int unsigned IMEM_DEPTH = 1024;
   localparam int unsigned IMEM_IDX_W = 10;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

   typedef enum logic {
      StLoad = 1'b0,
      StRun  = 1'b1
   } state_e;

endpackage

// File: rtl/imem_array.sv
// Synchronous single-port instruction RAM, no reset.
//   clk      : clock
//   we_i     : write strobe (takes the port; a write never updates rdata_o)
//   re_i     : read strobe, data appears on rdata_o after the next posedge
//   addr_i   : word index shared by read and write
//   wdata_i  : write data
//   rdata_o  : last read data, held until the next read
module imem_array
   import imem_responder_pkg::*;
#(
   parameter int unsigned DEPTH = IMEM_DEPTH,
   parameter int unsigned IDX_W = IMEM_IDX_W
) (
   input  logic             clk,
   input  logic             we_i,
   input  logic             re_i,
   input  logic [IDX_W-1:0] addr_i,
   input  logic [31:0]      wdata_i,
   output logic [31:0]      rdata_o
);

   logic [31:0] mem_q [DEPTH];
   logic [31:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[addr_i] <= wdata_i;
      end else if (re_i) begin
         rdata_q <= mem_q[addr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: program is loaded word by word in LOAD, then
// fetched with one-cycle latency in RUN.
//   clk, reset_n        : clock, asynchronous active-low reset
//   address, req, ready : fetch request (word address) and acceptance
//   instr, instr_valid  : response to the last accepted fetch
//   fault               : last accepted fetch was out of range
//   load_en/addr/data   : program-load write port (also forces return to LOAD)
//   run                 : pulse leaving LOAD
//   fetch_count         : wrapping count of accepted fetches
module imem_responder
   import imem_responder_pkg::*;
#(
   parameter int unsigned DEPTH = IMEM_DEPTH,
   parameter int unsigned IDX_W = IMEM_IDX_W
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [29:0]      address,
   input  logic             req,
   output logic             ready,
   output logic [31:0]      instr,
   output logic             instr_valid,
   output logic             fault,
   input  logic             load_en,
   input  logic [IDX_W-1:0] load_addr,
   input  logic [31:0]      load_data,
   input  logic             run,
   output logic [31:0]      fetch_count
);

   state_e           state_q;
   logic             valid_q;
   logic             fault_q;
   logic             from_ram_q;  // last response came from the RAM, not NOP
   logic [31:0]      count_q;
   logic [31:0]      count_d;
   logic             accept;
   logic             in_range;
   logic             ram_re;
   logic [IDX_W-1:0] ram_addr;
   logic [31:0]      ram_rdata;

   always_comb begin
      ready    = (state_q == StRun) && !load_en;
      accept   = req && ready;
      // Range check on the full address before any truncation to the index.
      in_range = (address[29:IDX_W] == '0);
      ram_re   = accept && in_range;
      ram_addr = load_en ? load_addr : address[IDX_W-1:0];
      count_d  = count_q + 32'd1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= StLoad;
         valid_q    <= 1'b0;
         fault_q    <= 1'b0;
         from_ram_q <= 1'b0;
         count_q    <= 32'd0;
      end else begin
         case (state_q)
            StLoad: if (run && !load_en) state_q <= StRun;
            StRun:  if (load_en) state_q <= StLoad;
         endcase
         valid_q <= accept;
         if (accept) begin
            fault_q    <= !in_range;
            from_ram_q <= in_range;
            count_q    <= count_d;
         end
      end
   end

   imem_array #(
      .DEPTH (DEPTH),
      .IDX_W (IDX_W)
   ) u_array (
      .clk     (clk),
      .we_i    (load_en),
      .re_i    (ram_re),
      .addr_i  (ram_addr),
      .wdata_i (load_data),
      .rdata_o (ram_rdata)
   );

   // RAM output is held between reads, so the hold-last-value behaviour of
   // instr falls out of the mux; from_ram_q clears on reset to force zero.
   assign instr       = from_ram_q ? ram_rdata : NOP_INSTR;
   assign instr_valid = valid_q;
   assign fault       = fault_q;
   assign fetch_count = count_q;

endmodule

// File: tb/tb_imem_responder.sv
module tb_imem_responder;

   localparam int DEPTH = 1024;
   localparam int IDX_W = 10;

   logic             clk = 1'b0;
   logic             reset_n;
   logic [29:0]      address;
   logic             req;
   logic             ready;
   logic [31:0]      instr;
   logic             instr_valid;
   logic             fault;
   logic             load_en;
   logic [IDX_W-1:0] load_addr;
   logic [31:0]      load_data;
   logic             run;
   logic [31:0]      fetch_count;

   always #5 clk = ~clk;

   imem_responder #(
      .DEPTH (DEPTH),
      .IDX_W (IDX_W)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .address     (address),
      .req         (req),
      .ready       (ready),
      .instr       (instr),
      .instr_valid (instr_valid),
      .fault       (fault),
      .load_en     (load_en),
      .load_addr   (load_addr),
      .load_data   (load_data),
      .run         (run),
      .fetch_count (fetch_count)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic             le;
      logic [IDX_W-1:0] la;
      logic [31:0]      ld;
      logic             rn;
      logic             rq;
      logic [29:0]      ad;
      logic             e_ready;
      logic             e_valid;
      logic [31:0]      e_instr;
      logic             e_fault;
      logic [31:0]      e_count;
   } vec_t;

   vec_t tbl[24];

   function automatic vec_t mk(input logic le, input logic [IDX_W-1:0] la, input logic [31:0] ld,
                               input logic rn, input logic rq, input logic [29:0] ad,
                               input logic e_ready, input logic e_valid,
                               input logic [31:0] e_instr, input logic e_fault,
                               input logic [31:0] e_count);
      vec_t v;
      v.le = le; v.la = la; v.ld = ld; v.rn = rn; v.rq = rq; v.ad = ad;
      v.e_ready = e_ready; v.e_valid = e_valid; v.e_instr = e_instr;
      v.e_fault = e_fault; v.e_count = e_count;
      return v;
   endfunction

   task automatic drive(input logic le, input logic [IDX_W-1:0] la, input logic [31:0] ld,
                        input logic rn, input logic rq, input logic [29:0] ad);
      load_en = le; load_addr = la; load_data = ld; run = rn; req = rq; address = ad;
   endtask

   // Behavioural reference: memory image, phase flag, and last response.
   logic [31:0] ref_mem [DEPTH];
   bit          m_running;
   logic [31:0] m_count;
   logic [31:0] m_instr;
   logic        m_fault;

   task automatic model_cycle(input logic le, input logic [IDX_W-1:0] la, input logic [31:0] ld,
                              input logic rn, input logic rq, input logic [29:0] ad);
      logic        e_ready;
      logic        e_valid;
      drive(le, la, ld, rn, rq, ad);
      e_ready = m_running && !le;
      e_valid = e_ready && rq;
      if (e_valid) begin
         m_count = m_count + 1;
         if ((ad >> IDX_W) != 0) begin
            m_instr = 32'h0;
            m_fault = 1'b1;
         end else begin
            m_instr = ref_mem[ad % DEPTH];
            m_fault = 1'b0;
         end
      end
      if (le) ref_mem[la] = ld;
      if (le) m_running = 0;
      else if (rn) m_running = 1;
      #1;
      chk("rnd_ready", {31'd0, ready}, {31'd0, e_ready});
      @(posedge clk);
      #1;
      chk("rnd_valid", {31'd0, instr_valid}, {31'd0, e_valid});
      chk("rnd_instr", instr, m_instr);
      chk("rnd_fault", {31'd0, fault}, {31'd0, m_fault});
      chk("rnd_count", fetch_count, m_count);
   endtask

   initial begin
      reset_n = 1'b0;
      drive(1'b0, '0, 32'h0, 1'b0, 1'b0, 30'h0);

      tbl[0]  = mk(1, 10'd0,   32'h20080005, 0, 1, 30'h0,        0, 0, 32'h0,        0, 0);
      tbl[1]  = mk(1, 10'd1,   32'h21290001, 0, 0, 30'h0,        0, 0, 32'h0,        0, 0);
      tbl[2]  = mk(0, 10'd0,   32'h0,        1, 0, 30'h0,        0, 0, 32'h0,        0, 0);
      tbl[3]  = mk(0, 10'd0,   32'h0,        0, 1, 30'h0,        1, 1, 32'h20080005, 0, 1);
      tbl[4]  = mk(0, 10'd0,   32'h0,        0, 1, 30'h1,        1, 1, 32'h21290001, 0, 2);
      tbl[5]  = mk(0, 10'd0,   32'h0,        0, 1, 30'h400,      1, 1, 32'h0,        1, 3);
      tbl[6]  = mk(0, 10'd0,   32'h0,        0, 1, 30'h1,        1, 1, 32'h21290001, 0, 4);
      tbl[7]  = mk(0, 10'd0,   32'h0,        0, 0, 30'h1,        1, 0, 32'h21290001, 0, 4);
      tbl[8]  = mk(1, 10'd5,   32'hDEADBEEF, 0, 1, 30'h0,        0, 0, 32'h21290001, 0, 4);
      tbl[9]  = mk(0, 10'd0,   32'h0,        0, 1, 30'h0,        0, 0, 32'h21290001, 0, 4);
      tbl[10] = mk(0, 10'd0,   32'h0,        1, 0, 30'h0,        0, 0, 32'h21290001, 0, 4);
      tbl[11] = mk(0, 10'd0,   32'h0,        0, 1, 30'h5,        1, 1, 32'hDEADBEEF, 0, 5);
      tbl[12] = mk(0, 10'd0,   32'h0,        0, 1, 30'h3FFFFFFF, 1, 1, 32'h0,        1, 6);
      tbl[13] = mk(0, 10'd0,   32'h0,        0, 0, 30'h0,        1, 0, 32'h0,        1, 6);
      tbl[14] = mk(1, 10'h3FF, 32'hCAFEF00D, 0, 0, 30'h0,        0, 0, 32'h0,        1, 6);
      tbl[15] = mk(0, 10'd0,   32'h0,        1, 0, 30'h0,        0, 0, 32'h0,        1, 6);
      tbl[16] = mk(0, 10'd0,   32'h0,        0, 1, 30'h3FF,      1, 1, 32'hCAFEF00D, 0, 7);
      tbl[17] = mk(0, 10'd0,   32'h0,        0, 1, 30'h7FF,      1, 1, 32'h0,        1, 8);
      tbl[18] = mk(1, 10'd2,   32'h11111111, 1, 0, 30'h0,        0, 0, 32'h0,        1, 8);
      tbl[19] = mk(1, 10'd3,   32'h22222222, 1, 0, 30'h0,        0, 0, 32'h0,        1, 8);
      tbl[20] = mk(0, 10'd0,   32'h0,        0, 1, 30'h2,        0, 0, 32'h0,        1, 8);
      tbl[21] = mk(0, 10'd0,   32'h0,        1, 0, 30'h0,        0, 0, 32'h0,        1, 8);
      tbl[22] = mk(0, 10'd0,   32'h0,        0, 1, 30'h2,        1, 1, 32'h11111111, 0, 9);
      tbl[23] = mk(0, 10'd0,   32'h0,        0, 1, 30'h3,        1, 1, 32'h22222222, 0, 10);

      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", {31'd0, ready}, 32'd0);
      chk("rst_valid", {31'd0, instr_valid}, 32'd0);
      chk("rst_instr", instr, 32'd0);
      chk("rst_fault", {31'd0, fault}, 32'd0);
      chk("rst_count", fetch_count, 32'd0);
      reset_n = 1'b1;

      // Directed table.
      for (int i = 0; i < 24; i++) begin
         drive(tbl[i].le, tbl[i].la, tbl[i].ld, tbl[i].rn, tbl[i].rq, tbl[i].ad);
         #1;
         chk($sformatf("tbl%0d_ready", i), {31'd0, ready}, {31'd0, tbl[i].e_ready});
         @(posedge clk);
         #1;
         chk($sformatf("tbl%0d_valid", i), {31'd0, instr_valid}, {31'd0, tbl[i].e_valid});
         chk($sformatf("tbl%0d_instr", i), instr, tbl[i].e_instr);
         chk($sformatf("tbl%0d_fault", i), {31'd0, fault}, {31'd0, tbl[i].e_fault});
         chk($sformatf("tbl%0d_count", i), fetch_count, tbl[i].e_count);
      end

      // Reset mid-stream: outputs clear at once, memory survives.
      drive(1'b0, '0, 32'h0, 1'b0, 1'b1, 30'h0);
      @(posedge clk);
      #1;
      chk("pre_rst_valid", {31'd0, instr_valid}, 32'd1);
      chk("pre_rst_instr", instr, 32'h20080005);
      chk("pre_rst_count", fetch_count, 32'd11);
      #2;
      reset_n = 1'b0;
      #1;
      chk("async_rst_ready", {31'd0, ready}, 32'd0);
      chk("async_rst_valid", {31'd0, instr_valid}, 32'd0);
      chk("async_rst_instr", instr, 32'd0);
      chk("async_rst_fault", {31'd0, fault}, 32'd0);
      chk("async_rst_count", fetch_count, 32'd0);
      @(posedge clk);
      #1;
      chk("hold_rst_valid", {31'd0, instr_valid}, 32'd0);
      reset_n = 1'b1;
      #1;
      chk("release_ready", {31'd0, ready}, 32'd0);
      @(posedge clk);
      #1;
      chk("release_valid", {31'd0, instr_valid}, 32'd0);
      chk("release_count", fetch_count, 32'd0);
      drive(1'b0, '0, 32'h0, 1'b1, 1'b0, 30'h0);
      @(posedge clk);
      #1;
      drive(1'b0, '0, 32'h0, 1'b0, 1'b1, 30'h0);
      @(posedge clk);
      #1;
      chk("retained_valid", {31'd0, instr_valid}, 32'd1);
      chk("retained_instr", instr, 32'h20080005);
      chk("retained_count", fetch_count, 32'd1);

      // Randomized run against the reference model, from a fresh reset.
      reset_n = 1'b0;
      #2;
      reset_n = 1'b1;
      m_running = 0;
      m_count   = 32'd0;
      m_instr   = 32'd0;
      m_fault   = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         model_cycle(1'b1, IDX_W'(i), $urandom, 1'b0, 1'($urandom), 30'($urandom));
      end
      model_cycle(1'b0, '0, 32'h0, 1'b1, 1'b0, 30'h0);
      for (int i = 0; i < 1500; i++) begin
         logic [29:0] ad;
         logic        le;
         logic        rn;
         logic        rq;
         if ($urandom_range(7) == 0) ad = {20'($urandom_range(1, 20'hFFFFF)), 10'($urandom)};
         else ad = {20'd0, 10'($urandom)};
         le = ($urandom_range(15) == 0);
         rn = ($urandom_range(7) == 0);
         rq = ($urandom_range(3) != 0);
         model_cycle(le, IDX_W'($urandom), $urandom, rn, rq, ad);
      end

      // Counter wrap.
      model_cycle(1'b0, '0, 32'h0, 1'b1, 1'b0, 30'h0);
      force dut.count_q = 32'hFFFF_FFFF;
      #1;
      release dut.count_q;
      #1;
      chk("wrap_preload", fetch_count, 32'hFFFF_FFFF);
      drive(1'b0, '0, 32'h0, 1'b0, 1'b1, 30'h1);
      @(posedge clk);
      #1;
      chk("wrap_count", fetch_count, 32'd0);
      chk("wrap_valid", {31'd0, instr_valid}, 32'd1);
      chk("wrap_instr", instr, ref_mem[1]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
